des_key_sched: RTL and testbench

Iterative DES key schedule for the DES datapath. It loads a 64-bit key, applies PC-1, and delivers one 48-bit round subkey per round-advance request from the round datapath. In encrypt mode the order is K1..K16; in decrypt mode it is K16..K1. It sits directly upstream of the round datapath whose 64-bit `state` feeds the state-monitor stage, and it sets the round pacing that the datapath and monitor observe.

---
 rtl/des_key_sched.sv | 146 ++++++++++++++
 tb/tb_des_key_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched.sv
// Iterative DES key schedule: PC-1 load, per-round C/D rotation, PC-2 out.
// Encrypt presents K1..K16, decrypt presents K16..K1.
module des_key_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key,
  input  logic        decrypt,
  input  logic        start,
  input  logic        next,
  output logic [47:0] subkey,
  output logic [3:0]  round,
  output logic        key_vld,
  output logic        last,
  output logic        busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_t      state;
  state_t      state_nx;
  logic [27:0] c_q;
  logic [27:0] d_q;
  logic        dir_q;
  logic        load;
  logic        adv;
  logic        done;
  logic        sh2;
  logic [55:0] cd_ld;
  logic [27:0] c_ld;
  logic [27:0] d_ld;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++)
      r[55-i] = k[64-PC1[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++)
      r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x,
                                       input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x,
                                       input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // S(n)==2 for every round except 1, 2, 9 and 16
  function automatic logic shift2(input logic [4:0] n);
    return !(n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16);
  endfunction

  // load value: encrypt pre-applies the round-1 shift so K1 is shown first
  always_comb begin
    cd_ld = pc1(key);
    c_ld  = decrypt ? cd_ld[55:28] : rotl(cd_ld[55:28], 1'b0);
    d_ld  = decrypt ? cd_ld[27:0]  : rotl(cd_ld[27:0], 1'b0);
    sh2   = dir_q ? shift2(5'd16 - {1'b0, round})
                  : shift2({1'b0, round} + 5'd2);
  end

  // next-state and control strobes
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    adv      = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        if (next) begin
          if (round == 4'd15) begin
            done     = 1'b1;
            state_nx = IDLE;
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // state, C/D, round counter and direction registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      c_q   <= '0;
      d_q   <= '0;
      round <= '0;
      dir_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        c_q   <= c_ld;
        d_q   <= d_ld;
        round <= '0;
        dir_q <= decrypt;
      end else if (adv) begin
        round <= round + 4'd1;
        c_q   <= dir_q ? rotr(c_q, sh2) : rotl(c_q, sh2);
        d_q   <= dir_q ? rotr(d_q, sh2) : rotl(d_q, sh2);
      end else if (done) begin
        round <= '0;
      end
    end
  end

  // outputs
  always_comb begin
    subkey  = pc2({c_q, d_q});
    key_vld = (state == ACTIVE);
    busy    = key_vld;
    last    = key_vld && (round == 4'd15);
  end

endmodule

// File: tb/tb_des_key_sched.sv
// Randomized self-checking bench for des_key_sched against a
// whole-schedule reference model.
module tb_des_key_sched;

  logic        clk;
  logic        rst;
  logic [63:0] key;
  logic        decrypt;
  logic        start;
  logic        next;
  logic [47:0] subkey;
  logic [3:0]  round;
  logic        key_vld;
  logic        last;
  logic        busy;

  int n_chk;
  int n_err;

  logic [47:0] exp_k [16];
  logic [47:0] got_k [16];
  logic [47:0] enc_k [16];

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEYP = 64'h123456789ABCDEF0;
  localparam logic [63:0] PMSK = 64'h0101010101010101;

  int pc1_t [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  int pc2_t [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_sched dut (
    .clk     (clk),
    .rst     (rst),
    .key     (key),
    .decrypt (decrypt),
    .start   (start),
    .next    (next),
    .subkey  (subkey),
    .round   (round),
    .key_vld (key_vld),
    .last    (last),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // full forward schedule K1..K16, reversed for decrypt
  task automatic build_ref(input logic [63:0] k, input bit dec);
    logic [27:0] c;
    logic [27:0] d;
    logic [55:0] cd;
    logic [47:0] ks [16];
    for (int i = 0; i < 28; i++) begin
      c[27-i] = k[64-pc1_t[i]];
      d[27-i] = k[64-pc1_t[i+28]];
    end
    for (int n = 0; n < 16; n++) begin
      repeat (shifts[n]) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++)
        ks[n][47-i] = cd[56-pc2_t[i]];
    end
    for (int i = 0; i < 16; i++)
      exp_k[i] = dec ? ks[15-i] : ks[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0 plain, 1 stray start at round 7, 2 start with final next
  task automatic run(input logic [63:0] k, input logic [63:0] rk,
                     input bit dec, input bit stall, input int mode);
    int gap;
    build_ref(rk, dec);
    key = k;
    decrypt = dec;
    start = 1'b1;
    next = 1'b0;
    tick();
    start = 1'b0;
    key = {$urandom, $urandom};
    decrypt = ~dec;
    for (int i = 0; i < 16; i++) begin
      got_k[i] = subkey;
      check("vld", key_vld, 1);
      check("busy", busy, 1);
      check("round", round, i);
      check("subkey", subkey, exp_k[i]);
      check("last", last, i == 15);
      if (mode == 1 && i == 7) begin
        key = ~k;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_start_sk", subkey, exp_k[i]);
        check("ign_start_rnd", round, i);
      end
      if (stall) begin
        gap = $urandom_range(0, 5);
        repeat (gap) begin
          tick();
          check("hold_sk", subkey, exp_k[i]);
          check("hold_rnd", round, i);
          check("hold_vld", key_vld, 1);
        end
      end
      next = 1'b1;
      if (mode == 2 && i == 15) begin
        start = 1'b1;
        key = ~k;
      end
      tick();
      next = 1'b0;
      start = 1'b0;
    end
    check("end_busy", busy, 0);
    check("end_vld", key_vld, 0);
    check("end_last", last, 0);
    check("end_round", round, 0);
    if (mode == 2) begin
      tick();
      check("no_reload_busy", busy, 0);
      check("no_reload_vld", key_vld, 0);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    key = '0;
    decrypt = 1'b0;
    start = 1'b0;
    next = 1'b0;
    tick();
    check("rst_subkey", subkey, 0);
    check("rst_round", round, 0);
    check("rst_vld", key_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_last", last, 0);
    rst = 1'b1;
    tick();

    next = 1'b1;
    repeat (3) begin
      tick();
      check("idle_next_rnd", round, 0);
      check("idle_next_vld", key_vld, 0);
    end
    next = 1'b0;
    tick();

    run(KEY1, KEY1, 1'b0, 1'b0, 0);
    check("kv_k1", got_k[0], 48'h1B02EFFC7072);
    check("kv_k2", got_k[1], 48'h79AED9DBC9E5);
    check("kv_k16", got_k[15], 48'hCB3D8B0E17F5);
    for (int i = 0; i < 16; i++) enc_k[i] = got_k[i];

    run(KEY1, KEY1, 1'b1, 1'b0, 0);
    check("dec_first", got_k[0], 48'hCB3D8B0E17F5);
    check("dec_last", got_k[15], 48'h1B02EFFC7072);
    for (int i = 0; i < 16; i++)
      check("dec_reverse", got_k[i], {16'h0, enc_k[15-i]});

    run(KEY1, KEY1, 1'b0, 1'b1, 0);
    run(KEY1, KEY1, 1'b0, 1'b0, 1);
    run(KEY1, KEY1, 1'b0, 1'b0, 2);

    key = KEY1;
    decrypt = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    next = 1'b1;
    repeat (9) tick();
    next = 1'b0;
    check("pre_rst_round", round, 9);
    #3;
    rst = 1'b0;
    #1;
    check("arst_subkey", subkey, 0);
    check("arst_round", round, 0);
    check("arst_vld", key_vld, 0);
    check("arst_busy", busy, 0);
    check("arst_last", last, 0);
    tick();
    rst = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst_vld", key_vld, 0);
      check("post_rst_sk", subkey, 0);
      check("post_rst_rnd", round, 0);
    end
    run(KEY1, KEY1, 1'b0, 1'b0, 0);

    run(KEYP, KEYP, 1'b0, 1'b0, 0);
    run(KEYP ^ PMSK, KEYP, 1'b0, 1'b0, 0);
    run(KEYP ^ PMSK, KEYP, 1'b1, 1'b0, 0);

    for (int t = 0; t < 6; t++) begin
      logic [63:0] rk;
      rk = {$urandom, $urandom};
      run(rk, rk, t[0], 1'b1, t % 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
